// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Definitions shared by the memory read and write controllers:
//   - FSM state encoding for the read controller
//   - bank chip-enable constants (active-low, one-hot)
//   - HOLD accept-timeout limit
//   - bank_ceb(): 2-bit bank select to active-low one-hot chip enable
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] CEB_IDLE  = 4'b1111;
    localparam logic [3:0] CEB_BANK0 = 4'b1110;
    localparam logic [3:0] CEB_BANK1 = 4'b1101;
    localparam logic [3:0] CEB_BANK2 = 4'b1011;
    localparam logic [3:0] CEB_BANK3 = 4'b0111;

    localparam logic [7:0] HOLD_LIMIT = 8'd255;

    function automatic logic [3:0] bank_ceb(input logic [1:0] sel);
        logic [3:0] ceb;
        case (sel)
            2'd0:    ceb = CEB_BANK0;
            2'd1:    ceb = CEB_BANK1;
            2'd2:    ceb = CEB_BANK2;
            default: ceb = CEB_BANK3;
        endcase
        return ceb;
    endfunction

endpackage

// File: rtl/mem_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl_if
// Bus between the read controller, the four bank macros and the consumer.
//   rd_req, memsel, rd_acpt : consumer request / bank select / accept
//   mem_q                   : bank read data, bank n at [n*DW +: DW]
//   ceb, web, addr          : bank chip enables, write enables, address
//   rd_data, rd_vld         : captured word and its valid flag
//   rd_err                  : one-cycle accept-timeout pulse
//   busy                    : controller not idle
// Modports: master = controller side, slave = bank/consumer side.
// -----------------------------------------------------------------------------
interface mem_rd_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic            rd_req;
    logic [1:0]      memsel;
    logic [4*DW-1:0] mem_q;
    logic            rd_acpt;
    logic [3:0]      ceb;
    logic [3:0]      web;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   rd_data;
    logic            rd_vld;
    logic            rd_err;
    logic            busy;

    modport master (
        input  rd_req, memsel, mem_q, rd_acpt,
        output ceb, web, addr, rd_data, rd_vld, rd_err, busy
    );

    modport slave (
        output rd_req, memsel, mem_q, rd_acpt,
        input  ceb, web, addr, rd_data, rd_vld, rd_err, busy
    );
endinterface

// File: rtl/bank_sel_dec.sv
// -----------------------------------------------------------------------------
// bank_sel_dec
// Bank select decoder shared by the read and write paths.
//   sel [1:0] in  : bank number
//   en        in  : assert the selected chip enable
//   ceb [3:0] out : active-low one-hot chip enables, all high when en=0
// -----------------------------------------------------------------------------
module bank_sel_dec
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] ceb
);
    always_comb begin
        ceb = CEB_IDLE;
        if (en) begin
            ceb = bank_ceb(sel);
        end
    end
endmodule

// File: rtl/mem_rd_ctrl.sv
// -----------------------------------------------------------------------------
// mem_rd_ctrl
// Single-word read controller for four memory banks. Each request advances
// the address pointer, strobes the selected bank for one cycle, captures the
// returned word after RD_LAT cycles and holds it until the consumer accepts.
//   clk  in : rising-edge clock
//   rstn in : synchronous active-low reset
//   bus     : mem_rd_ctrl_if.master (request/accept, bank bus, read data)
// Parameters: DW data width, AW address width, RD_LAT access latency (1..15).
// Optional feature: define MEM_RD_TIMEOUT_EN to drop an unaccepted word after
// HOLD_LIMIT idle HOLD cycles and pulse rd_err.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for rd_req, memsel captured on acceptance
// ST_ADDR   | advance address pointer
// ST_STROBE | selected bank chip enable low for this one cycle
// ST_WAIT   | count down access latency, capture mem_q at zero
// ST_HOLD   | rd_vld high until rd_acpt (or timeout)
// -----------------------------------------------------------------------------
module mem_rd_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    mem_rd_ctrl_if.master bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr_q;
    logic [1:0]    sel_q;
    logic [3:0]    wait_cnt;
    logic [DW-1:0] rd_data_q;
    logic          rd_vld_q;
    logic [3:0]    ceb_q;
    logic [3:0]    ceb_next;
    logic          timeout;

    // ceb is registered: decode against the next state so the strobe lines
    // up with the STROBE cycle without combinational glitches on the macros.
    bank_sel_dec u_bank_sel_dec (
        .sel (sel_q),
        .en  (state_next == ST_STROBE),
        .ceb (ceb_next)
    );

`ifdef MEM_RD_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       rd_err_q;

    // accept in the same cycle as the limit takes precedence
    assign timeout = (state == ST_HOLD) && (hold_cnt == HOLD_LIMIT) && !bus.rd_acpt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_cnt <= 8'd0;
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= timeout;
            if (state == ST_WAIT && wait_cnt == 4'd0) begin
                hold_cnt <= 8'd0;
            end else if (state == ST_HOLD && !bus.rd_acpt && hold_cnt != HOLD_LIMIT) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign bus.rd_err = rd_err_q;
`else
    assign timeout    = 1'b0;
    assign bus.rd_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR:   state_next = ST_STROBE;
            ST_STROBE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.rd_acpt || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= 2'd0;
            wait_cnt  <= 4'd0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            ceb_q     <= CEB_IDLE;
        end else begin
            state <= state_next;
            ceb_q <= ceb_next;
            case (state)
                ST_IDLE: begin
                    if (bus.rd_req) begin
                        sel_q <= bus.memsel;
                    end
                end
                ST_ADDR: begin
                    addr_q <= addr_q + 1'b1;
                end
                ST_STROBE: begin
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rd_data_q <= bus.mem_q[int'(sel_q)*DW +: DW];
                        rd_vld_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.rd_acpt || timeout) begin
                        rd_vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ceb     = ceb_q;
    assign bus.web     = CEB_IDLE;
    assign bus.addr    = addr_q;
    assign bus.rd_data = rd_data_q;
    assign bus.rd_vld  = rd_vld_q;
    assign bus.busy    = (state != ST_IDLE);

endmodule
